// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path and its FIFO.
// Holds the receiver FSM state encoding, the parity mode constants and a
// ceiling-log2 helper used to size pointers and occupancy counters.
package uart_rx_fifo_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Smallest w with 2**w >= value.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (pointers/count only)
//   i_wr, i_wdata    write strobe and word
//   i_rd             read strobe, ignored while empty
//   o_rdata          head word, valid while !o_empty
//   o_empty, o_full  occupancy status
//   o_count          occupancy, 0..DEPTH
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic                    i_rd,
    output logic [WIDTH-1:0]        o_rdata,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [clog2(DEPTH):0]   o_count
);

    localparam int              AW         = clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_COUNT);
    assign o_count = r_count;

    // A read frees a slot in the same cycle, so a full FIFO still accepts
    // a write when it is being read; a read of an empty FIFO is dropped.
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (w_do_wr) r_wptr <= r_wptr + 1'b1;
            if (w_do_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (configurable width/parity) feeding a
// first-word-fall-through receive FIFO, with sticky error flags.
// Ports:
//   Clk_100M   sole clock
//   Reset      synchronous active-high reset
//   Rx         asynchronous serial line, idle high
//   Ack        pop strobe for the FIFO head
//   ErrClr     clears Overrun/FrameErr/ParityErr
//   Data       FIFO head word, valid while Ready
//   Ready      FIFO non-empty
//   Count      FIFO occupancy
//   Overrun    word arrived while FIFO full (sticky)
//   FrameErr   stop bit sampled low (sticky)
//   ParityErr  parity bit mismatch (sticky)
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         Clk_100M,
    input  logic                         Reset,
    input  logic                         Rx,
    input  logic                         Ack,
    input  logic                         ErrClr,
    output logic [DATA_BITS-1:0]         Data,
    output logic                         Ready,
    output logic [clog2(FIFO_DEPTH):0]   Count,
    output logic                         Overrun,
    output logic                         FrameErr,
    output logic                         ParityErr
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BAUD_HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [2:0]           r_state;
    logic [15:0]          r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_push;
    logic                 r_overrun;
    logic                 r_frame_err;
    logic                 r_parity_err;

    logic                 w_bit_tick;
    logic                 w_par_expect;
    logic                 w_par_evt;
    logic                 w_frame_evt;
    logic                 w_ovr_evt;
    logic                 w_empty;
    logic                 w_full;

    // Two-flop synchroniser, preset to the idle (high) level.
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_bit_tick   = (r_baud == BAUD_LAST);
    // Parity bit value that makes the frame's ones-count match the mode.
    assign w_par_expect = (PARITY == PAR_ODD) ? ~(^r_shift) : (^r_shift);
    assign w_par_evt    = (r_state == ST_PARITY) && w_bit_tick &&
                          (r_rx_sync != w_par_expect);
    assign w_frame_evt  = (r_state == ST_STOP) && w_bit_tick && !r_rx_sync;
    assign w_ovr_evt    = r_push && w_full && !Ack;

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_par_bad <= 1'b0;
            r_push    <= 1'b0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                // Every entry into IDLE happens with the line high, so a
                // low level here is always a fresh falling edge.
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= ST_START;
                        r_baud  <= '0;
                    end
                end
                ST_START: begin
                    if (r_baud == BAUD_HALF) begin
                        r_baud    <= '0;
                        r_bit     <= '0;
                        r_par_bad <= 1'b0;
                        r_state   <= r_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        r_baud <= '0;
                        r_bit  <= r_bit + 4'd1;
                        if (r_bit == BIT_LAST) begin
                            r_state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_baud    <= '0;
                        r_par_bad <= (r_rx_sync != w_par_expect);
                        r_state   <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_tick) begin
                        r_baud <= '0;
                        if (r_rx_sync) begin
                            r_push  <= !r_par_bad;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_BREAK: begin
                    if (r_rx_sync) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Payload shifts in LSB first; it stays put from the last data sample
    // until the next frame, so it doubles as the push word.
    always_ff @(posedge Clk_100M) begin
        if ((r_state == ST_DATA) && w_bit_tick) begin
            r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
        end
    end

    // Sticky flags: a new error outranks a simultaneous clear.
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_ovr_evt)       r_overrun    <= 1'b1;
            else if (ErrClr)     r_overrun    <= 1'b0;
            if (w_frame_evt)     r_frame_err  <= 1'b1;
            else if (ErrClr)     r_frame_err  <= 1'b0;
            if (w_par_evt)       r_parity_err <= 1'b1;
            else if (ErrClr)     r_parity_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Clk_100M),
        .i_rst   (Reset),
        .i_wr    (r_push),
        .i_wdata (r_shift),
        .i_rd    (Ack),
        .o_rdata (Data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (Count)
    );

    assign Ready     = !w_empty;
    assign Overrun   = r_overrun;
    assign FrameErr  = r_frame_err;
    assign ParityErr = r_parity_err;

endmodule
